// File: rtl/pipe_skid_stage_pkg.sv
// Shared encodings and default widths for the skid-buffered stage register.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pipe_skid_stage_pkg;

    // Default widths used by the pipeline stage registers.
    localparam int PC_W_DEF   = 64;
    localparam int INST_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 64;
    localparam int CNT_W_DEF  = 32;

    // addi x0, x0, 0: the canonical NOP shown on a bubble.
    localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;

    localparam logic ZERO_BIT = 1'b0;
    localparam logic ONE_BIT  = 1'b1;

    // Occupancy of the two-entry buffer.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } skid_state_e;

endpackage

// File: rtl/pipe_entry_reg.sv
// Payload register for one beat (pc, instr, write triple).
// Latency: 1 cycle from load to q.
// Backpressure: none; the caller decides when to load.
module pipe_entry_reg
    import pipe_skid_stage_pkg::*;
#(
    parameter int PC_W   = PC_W_DEF,
    parameter int INST_W = INST_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              load,
    input  logic [PC_W-1:0]   nxt_pc,
    input  logic [INST_W-1:0] nxt_instr,
    input  logic              nxt_w_ena,
    input  logic [ADDR_W-1:0] nxt_w_addr,
    input  logic [DATA_W-1:0] nxt_w_data,
    output logic [PC_W-1:0]   pc,
    output logic [INST_W-1:0] instr,
    output logic              w_ena,
    output logic [ADDR_W-1:0] w_addr,
    output logic [DATA_W-1:0] w_data
);

    // Clear wins over load; otherwise capture the payload when loaded and hold it.
    always_ff @(posedge clock) begin
        if (clear) begin
            pc     <= '0;
            instr  <= '0;
            w_ena  <= ZERO_BIT;
            w_addr <= '0;
            w_data <= '0;
        end else if (load) begin
            pc     <= nxt_pc;
            instr  <= nxt_instr;
            w_ena  <= nxt_w_ena;
            w_addr <= nxt_w_addr;
            w_data <= nxt_w_data;
        end
    end

endmodule

// File: rtl/pipe_skid_stage.sv
// Two-entry skid-buffered stage register with flush, bubble sanitising and stall counter.
// Latency: 1 cycle from in_fire to out_valid when empty; one beat per cycle at full rate.
// Backpressure: in_ready is registered (low only when both entries are full), no path from out_ready.
module pipe_skid_stage
    import pipe_skid_stage_pkg::*;
#(
    parameter int                PC_W     = PC_W_DEF,
    parameter int                INST_W   = INST_W_DEF,
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter int                DATA_W   = DATA_W_DEF,
    parameter logic [INST_W-1:0] NOP_INST = INST_W'(NOP_INST_DEF),
    parameter int                CNT_W    = CNT_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [INST_W-1:0] in_instr,
    input  logic              in_w_ena,
    input  logic [ADDR_W-1:0] in_w_addr,
    input  logic [DATA_W-1:0] in_w_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic [INST_W-1:0] out_instr,
    output logic              out_w_ena,
    output logic [ADDR_W-1:0] out_w_addr,
    output logic [DATA_W-1:0] out_w_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    skid_state_e      state;
    logic             in_ready_q;
    logic [CNT_W-1:0] stall_cnt_q;

    logic [PC_W-1:0]   main_pc,     skid_pc,     main_nxt_pc;
    logic [INST_W-1:0] main_instr,  skid_instr,  main_nxt_instr;
    logic              main_w_ena,  skid_w_ena,  main_nxt_w_ena;
    logic [ADDR_W-1:0] main_w_addr, skid_w_addr, main_nxt_w_addr;
    logic [DATA_W-1:0] main_w_data, skid_w_data, main_nxt_w_data;

    logic in_fire, out_fire, load_main, load_skid;

    assign in_ready  = in_ready_q;
    assign out_valid = (state != ST_EMPTY) & ~flush;
    assign in_fire   = in_valid & in_ready_q;
    assign out_fire  = out_valid & out_ready;

    // Main refills from the skid when draining TWO, otherwise straight from upstream.
    assign load_main = ~flush & (((state == ST_EMPTY) & in_fire) |
                                 ((state == ST_ONE) & in_fire & out_fire) |
                                 ((state == ST_TWO) & out_fire));
    assign load_skid = ~flush & (state == ST_ONE) & in_fire & ~out_fire;

    assign main_nxt_pc     = (state == ST_TWO) ? skid_pc     : in_pc;
    assign main_nxt_instr  = (state == ST_TWO) ? skid_instr  : in_instr;
    assign main_nxt_w_ena  = (state == ST_TWO) ? skid_w_ena  : in_w_ena;
    assign main_nxt_w_addr = (state == ST_TWO) ? skid_w_addr : in_w_addr;
    assign main_nxt_w_data = (state == ST_TWO) ? skid_w_data : in_w_data;

    pipe_entry_reg #(.PC_W(PC_W), .INST_W(INST_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_main (
        .clock(clock), .clear(reset), .load(load_main),
        .nxt_pc(main_nxt_pc), .nxt_instr(main_nxt_instr), .nxt_w_ena(main_nxt_w_ena),
        .nxt_w_addr(main_nxt_w_addr), .nxt_w_data(main_nxt_w_data),
        .pc(main_pc), .instr(main_instr), .w_ena(main_w_ena),
        .w_addr(main_w_addr), .w_data(main_w_data)
    );

    pipe_entry_reg #(.PC_W(PC_W), .INST_W(INST_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_skid (
        .clock(clock), .clear(reset), .load(load_skid),
        .nxt_pc(in_pc), .nxt_instr(in_instr), .nxt_w_ena(in_w_ena),
        .nxt_w_addr(in_w_addr), .nxt_w_data(in_w_data),
        .pc(skid_pc), .instr(skid_instr), .w_ena(skid_w_ena),
        .w_addr(skid_w_addr), .w_data(skid_w_data)
    );

    // Occupancy FSM; in_ready is registered from the next state so it never sees out_ready.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            state      <= ST_EMPTY;
            in_ready_q <= ONE_BIT;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state      <= ST_ONE;
                        in_ready_q <= ONE_BIT;
                    end
                end
                ST_ONE: begin
                    if (in_fire && !out_fire) begin
                        state      <= ST_TWO;
                        in_ready_q <= ZERO_BIT;
                    end else if (!in_fire && out_fire) begin
                        state      <= ST_EMPTY;
                        in_ready_q <= ONE_BIT;
                    end
                end
                ST_TWO: begin
                    if (out_fire) begin
                        state      <= ST_ONE;
                        in_ready_q <= ONE_BIT;
                    end
                end
                default: begin
                    state      <= ST_EMPTY;
                    in_ready_q <= ONE_BIT;
                end
            endcase
        end
    end

    // Saturating count of cycles where a presented beat is held back; only reset clears it.
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else if (out_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    assign stall_cnt = stall_cnt_q;

    // Bubbles show a harmless NOP with no write; address/data keep the last beat's value.
    assign out_pc     = out_valid ? main_pc    : '0;
    assign out_instr  = out_valid ? main_instr : NOP_INST;
    assign out_w_ena  = main_w_ena & out_valid;
    assign out_w_addr = main_w_addr;
    assign out_w_data = main_w_data;

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Scoreboard bench for pipe_skid_stage: accepted beats are queued, a negedge monitor checks commits.
// Latency: n/a.
// Backpressure: driven by directed out_ready patterns.
module tb_pipe_skid_stage;

    logic        clock = 1'b0;
    logic        reset, flush, in_valid, out_ready;
    logic [63:0] in_pc;
    logic [31:0] in_instr;
    logic        in_w_ena;
    logic [4:0]  in_w_addr;
    logic [63:0] in_w_data;

    logic        in_ready, out_valid, out_w_ena;
    logic [63:0] out_pc, out_w_data;
    logic [31:0] out_instr;
    logic [4:0]  out_w_addr;
    logic [31:0] stall_cnt;

    logic        s_in_ready, s_out_valid, s_out_w_ena;
    logic [63:0] s_out_pc, s_out_w_data;
    logic [31:0] s_out_instr;
    logic [4:0]  s_out_w_addr;
    logic [2:0]  s_stall_cnt;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
        logic        we;
        logic [4:0]  addr;
        logic [63:0] data;
    } beat_t;

    beat_t exp_q[$];
    int    errors = 0;
    int    checks = 0;

    always #5 clock = ~clock;

    pipe_skid_stage u_dut (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
        .in_w_ena(in_w_ena), .in_w_addr(in_w_addr), .in_w_data(in_w_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
        .out_w_ena(out_w_ena), .out_w_addr(out_w_addr), .out_w_data(out_w_data),
        .stall_cnt(stall_cnt)
    );

    pipe_skid_stage #(.CNT_W(3)) u_sat (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_pc(in_pc), .in_instr(in_instr),
        .in_w_ena(in_w_ena), .in_w_addr(in_w_addr), .in_w_data(in_w_data),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_pc(s_out_pc), .out_instr(s_out_instr),
        .out_w_ena(s_out_w_ena), .out_w_addr(s_out_w_addr), .out_w_data(s_out_w_data),
        .stall_cnt(s_stall_cnt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Offer one beat for one cycle; queue it as expected only if the stage takes it.
    task automatic send(input logic [63:0] pc, input logic [31:0] ins, input logic we,
                        input logic [4:0] a, input logic [63:0] d);
        beat_t b;
        in_valid = 1'b1; in_pc = pc; in_instr = ins; in_w_ena = we; in_w_addr = a; in_w_data = d;
        if (in_ready && !flush && !reset) begin
            b.pc = pc; b.instr = ins; b.we = we; b.addr = a; b.data = d;
            exp_q.push_back(b);
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " in_ready"},   64'(in_ready),   64'd1);
        chk({tag, " out_valid"},  64'(out_valid),  64'd0);
        chk({tag, " out_pc"},     out_pc,          64'd0);
        chk({tag, " out_instr"},  64'(out_instr),  64'h13);
        chk({tag, " out_w_ena"},  64'(out_w_ena),  64'd0);
        chk({tag, " out_w_addr"}, 64'(out_w_addr), 64'd0);
        chk({tag, " out_w_data"}, out_w_data,      64'd0);
        chk({tag, " stall_cnt"},  64'(stall_cnt),  64'd0);
    endtask

    // Monitor: every committed beat must match the oldest expected beat.
    always @(negedge clock) begin
        beat_t e;
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL commit: unexpected beat pc=%h with no beat expected", out_pc);
            end else begin
                e = exp_q.pop_front();
                chk("commit pc",     out_pc,              e.pc);
                chk("commit instr",  64'(out_instr),      64'(e.instr));
                chk("commit w_ena",  64'(out_w_ena),      64'(e.we));
                chk("commit w_addr", 64'(out_w_addr),     64'(e.addr));
                chk("commit w_data", out_w_data,          e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_pc = '0; in_instr = '0; in_w_ena = 1'b0; in_w_addr = '0; in_w_data = '0;
        repeat (3) tick();
        chk_reset_vals("reset");
        reset = 1'b0;
        tick();

        // Streaming: each beat visible the cycle after acceptance; beat 2 carries w_ena=0.
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("stream in_ready", 64'(in_ready), 64'd1);
            send(64'h8000_0000 + 64'(4 * i), 32'h0000_0100 + 32'(i), (i != 2), 5'(i + 1), 64'(i + 16));
            chk("stream out_valid", 64'(out_valid), 64'd1);
            chk("stream out_pc", out_pc, 64'h8000_0000 + 64'(4 * i));
        end
        tick();
        chk("stream drained", 64'(out_valid), 64'd0);
        chk("stream stall_cnt", 64'(stall_cnt), 64'd0);

        // Back-pressure fill: A in main, B in skid, then drain A then B.
        out_ready = 1'b0;
        send(64'hA000, 32'h0000_0A13, 1'b1, 5'd10, 64'hAAAA);
        send(64'hB000, 32'h0000_0B13, 1'b1, 5'd11, 64'hBBBB);
        chk("fill in_ready", 64'(in_ready), 64'd0);
        chk("fill out_pc A", out_pc, 64'hA000);
        tick();
        chk("fill stall_cnt", 64'(stall_cnt), 64'd2);
        out_ready = 1'b1;
        tick();
        chk("drain out_pc B", out_pc, 64'hB000);
        chk("drain in_ready", 64'(in_ready), 64'd1);
        tick();
        chk("drain empty", 64'(out_valid), 64'd0);
        chk("drain stall_cnt", 64'(stall_cnt), 64'd2);

        // Flush while full with a new beat C offered: nothing commits, C is dropped.
        out_ready = 1'b0;
        send(64'hD000, 32'h0000_0D13, 1'b1, 5'd13, 64'hDDDD);
        send(64'hE000, 32'h0000_0E13, 1'b1, 5'd14, 64'hEEEE);
        flush = 1'b1; out_ready = 1'b1;
        in_valid = 1'b1; in_pc = 64'hC000; in_instr = 32'h0000_0C13;
        in_w_ena = 1'b1; in_w_addr = 5'd12; in_w_data = 64'hCCCC;
        exp_q.delete();
        #1;
        chk("flush out_valid masked", 64'(out_valid), 64'd0);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("post-flush out_valid", 64'(out_valid), 64'd0);
        chk("post-flush in_ready", 64'(in_ready), 64'd1);
        chk("post-flush stall_cnt kept", 64'(stall_cnt), 64'd3);
        repeat (2) tick();

        // Bubble sanitising after a write beat drains.
        send(64'hF000, 32'h0000_0F13, 1'b1, 5'd5, 64'h1234);
        tick();
        chk("bubble out_valid", 64'(out_valid), 64'd0);
        chk("bubble out_w_ena", 64'(out_w_ena), 64'd0);
        chk("bubble out_pc", out_pc, 64'd0);
        chk("bubble out_instr", 64'(out_instr), 64'h13);
        chk("bubble out_w_addr", 64'(out_w_addr), 64'd5);
        chk("bubble out_w_data", out_w_data, 64'h1234);

        // Reset while full with stall_cnt at 7.
        out_ready = 1'b0;
        send(64'h1000, 32'h0000_1013, 1'b1, 5'd1, 64'h1);
        send(64'h2000, 32'h0000_2013, 1'b1, 5'd2, 64'h2);
        repeat (3) tick();
        chk("pre-reset stall_cnt", 64'(stall_cnt), 64'd7);
        chk("pre-reset in_ready", 64'(in_ready), 64'd0);
        reset = 1'b1;
        exp_q.delete();
        tick();
        chk_reset_vals("midreset");
        reset = 1'b0;
        tick();

        // Saturation: 10 held cycles, 3-bit counter stops at 7.
        send(64'h3000, 32'h0000_3013, 1'b0, 5'd3, 64'h3);
        repeat (10) tick();
        chk("sat stall_cnt 3-bit", 64'(s_stall_cnt), 64'd7);
        chk("sat stall_cnt 32-bit", 64'(stall_cnt), 64'd10);
        out_ready = 1'b1;
        repeat (3) tick();
        chk("scoreboard empty", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
